// File: rtl/run_launcher_pkg.sv
// Shared types and defaults for the run_launcher kernel sequencer.
package run_launcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4,
    ST_FIN       = 3'd5
  } state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned WDOG_CYCLES_DEF = 1024;

endpackage

// File: rtl/run_wdog.sv
// Clear/enable/expire ce-cycle counter bounding one handshake wait.
module run_wdog
  import run_launcher_pkg::*;
#(
  parameter int unsigned LIMIT = WDOG_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic ce,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (ce) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

  // Fires on the LIMIT-th enabled cycle after the last clear.
  assign o_expire_c = i_en && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/run_launcher.sv
// Launches a kernel i_count times back to back and tallies runs and true results.
// Optional watchdog on the handshake waits: define RUN_LAUNCHER_WDOG_EN.
module run_launcher
  import run_launcher_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_iter_done,
  output logic [CNT_W-1:0] o_true_cnt,
  output logic             o_timeout,
  output logic             o_kern_req,
  input  logic             i_kern_busy,
  input  logic             i_kern_flag
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_iter_done;
  logic [CNT_W-1:0] w_iter_nxt;
  logic [CNT_W-1:0] r_true_cnt;
  logic [CNT_W-1:0] w_true_nxt;
  logic [CNT_W-1:0] w_iter_inc;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_kern_req;
  logic             w_expire_c;

  assign w_iter_inc = r_iter_done + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_iter_nxt    = r_iter_done;
    w_true_nxt    = r_true_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_count_nxt   = i_count;
          w_iter_nxt    = '0;
          w_true_nxt    = '0;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = (i_count != '0) ? ST_REQ : ST_FIN;
        end
      end
      ST_REQ: w_state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i_kern_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (w_expire_c) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_FIN;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_kern_busy) begin
          w_iter_nxt  = w_iter_inc;
          w_true_nxt  = r_true_cnt + CNT_W'(i_kern_flag);
          w_state_nxt = (w_iter_inc == r_count) ? ST_FIN : ST_GAP;
        end else if (w_expire_c) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_FIN;
        end
      end
      ST_GAP:  w_state_nxt = ST_REQ;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_iter_done <= '0;
      r_true_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_kern_req  <= 1'b0;
    end else if (ce) begin
      r_count     <= w_count_nxt;
      r_iter_done <= w_iter_nxt;
      r_true_cnt  <= w_true_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_FIN);
      r_kern_req  <= (w_state_nxt == ST_REQ);
    end
  end

`ifdef RUN_LAUNCHER_WDOG_EN
  logic w_wait_c;
  logic w_wdog_clr_c;
  assign w_wait_c     = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE);
  assign w_wdog_clr_c = (w_state_nxt != r_state);

  run_wdog #(
    .LIMIT (WDOG_CYCLES)
  ) u_wdog (
    .clock      (clock),
    .reset_n    (reset_n),
    .ce         (ce),
    .i_clr      (w_wdog_clr_c),
    .i_en       (w_wait_c),
    .o_expire_c (w_expire_c)
  );
`else
  // Without the watchdog the waits are unbounded and the budget is irrelevant.
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYCLES == 0);
  assign w_expire_c    = 1'b0;
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_iter_done = r_iter_done;
  assign o_true_cnt  = r_true_cnt;
  assign o_timeout   = r_timeout;
  assign o_kern_req  = r_kern_req;

endmodule

// File: tb/tb_run_launcher.sv
// Bench for run_launcher: kernel model plus count/latency reference from the run rules.
module tb_run_launcher;
  import run_launcher_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WDOG  = 8;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             ce      = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_count = '0;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_iter_done;
  logic [CNT_W-1:0] o_true_cnt;
  logic             o_timeout;
  logic             o_kern_req;
  logic             k_busy;
  logic             k_flag;

  int  k_left;
  int  k_runs;
  int  busy_len = 5;
  bit  kern_en  = 1'b1;
  logic flag_pat [64];
  int  run_base = 0;

  int  cyc = 0;
  int  req_hi = 0, req_rise = 0, done_rise = 0;
  logic req_q = 1'b0, done_q = 1'b0;
  int  start_cyc = 0;
  int  checks = 0, errors = 0;

  run_launcher #(
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ce          (ce),
    .i_start     (i_start),
    .i_count     (i_count),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_iter_done (o_iter_done),
    .o_true_cnt  (o_true_cnt),
    .o_timeout   (o_timeout),
    .o_kern_req  (o_kern_req),
    .i_kern_busy (k_busy),
    .i_kern_flag (k_flag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Kernel: ce-gated, accepts a request when idle, busy for busy_len ce-cycles.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_busy <= 1'b0; k_left <= 0; k_runs <= 0; k_flag <= 1'b0;
    end else if (ce) begin
      if (!k_busy) begin
        if (o_kern_req && kern_en) begin
          k_busy <= 1'b1;
          k_left <= busy_len - 1;
          k_runs <= k_runs + 1;
          k_flag <= flag_pat[(k_runs - run_base) & 63];
        end
      end else if (k_left == 0) begin
        k_busy <= 1'b0;
      end else begin
        k_left <= k_left - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (o_kern_req) req_hi++;
    if (o_kern_req && !req_q) req_rise++;
    if (o_done && !done_q) done_rise++;
    req_q  = o_kern_req;
    done_q = o_done;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input int cnt);
    @(negedge clock); #1;
    i_start = 1'b1; i_count = CNT_W'(cnt); ce = 1'b1;
    @(posedge clock); #1 start_cyc = cyc;
    @(negedge clock); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ce, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (o_done) begin seen = 1'b1; break; end
      if (rand_ce) ce = ($urandom_range(0, 3) != 0);
      @(negedge clock); #1;
    end
    ce = 1'b1;
  endtask

  // Launch, wait, and compare against the expected totals and ce-high latency.
  task automatic run_cmd(input int cnt, input int len, input bit rand_ce,
                         input bit use_pat, input logic [7:0] pat);
    int exp_true, r0, rr0, d0, k0;
    bit seen;
    busy_len = len;
    exp_true = 0;
    for (int i = 0; i < 64; i++) begin
      flag_pat[i] = use_pat ? ((i < 8) ? pat[i] : 1'b0) : 1'($urandom_range(0, 1));
      if (i < cnt && flag_pat[i]) exp_true++;
    end
    run_base = k_runs; r0 = req_hi; rr0 = req_rise; d0 = done_rise; k0 = k_runs;
    launch(cnt);
    wait_done(rand_ce, seen);
    chk("done_seen", 32'(seen), 1);
    chk("iter_done", 32'(o_iter_done), cnt);
    chk("true_cnt", 32'(o_true_cnt), exp_true);
    chk("timeout_clr", 32'(o_timeout), 0);
    chk("busy_in_fin", 32'(o_busy), 1);
    if (!rand_ce) chk("latency", cyc - start_cyc, (cnt == 0) ? 0 : cnt * (len + 3) - 1);
    @(negedge clock); #1;
    chk("idle_busy", 32'(o_busy), 0);
    chk("done_1cyc", 32'(o_done), 0);
    chk("req_rises", req_rise - rr0, cnt);
    chk("kern_runs", k_runs - k0, cnt);
    chk("done_rises", done_rise - d0, 1);
    if (!rand_ce) chk("req_cycles", req_hi - r0, cnt);
  endtask

  initial begin
    int r0, k0, exp_true, lim;
    bit seen;
    for (int i = 0; i < 64; i++) flag_pat[i] = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_iter", 32'(o_iter_done), 0);
    chk("rst_true", 32'(o_true_cnt), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_req", 32'(o_kern_req), 0);
    @(negedge clock); reset_n = 1'b1;

    // count 3, busy 5, flags 1,0,1
    run_cmd(3, 5, 1'b0, 1'b1, 8'b0000_0101);
    run_cmd(0, 5, 1'b0, 1'b1, 8'b0000_0000);

    // start re-asserted mid-run is ignored
    busy_len = 4; run_base = k_runs; k0 = k_runs;
    exp_true = 0;
    for (int i = 0; i < 64; i++) begin
      flag_pat[i] = 1'($urandom_range(0, 1));
      if (i < 2 && flag_pat[i]) exp_true++;
    end
    launch(2);
    for (int j = 0; j < 3; j++) begin
      repeat (3) @(negedge clock);
      #1 i_start = 1'b1; i_count = 16'd7;
      @(negedge clock); #1 i_start = 1'b0;
    end
    wait_done(1'b0, seen);
    chk("rs_seen", 32'(seen), 1);
    chk("rs_iter", 32'(o_iter_done), 2);
    chk("rs_true", 32'(o_true_cnt), exp_true);
    chk("rs_runs", k_runs - k0, 2);
    @(negedge clock); #1;

    // ce 1,0,0,1 around REQ stretches the request, kernel runs once
    busy_len = 3; flag_pat[0] = 1'b1; run_base = k_runs; k0 = k_runs; r0 = req_hi;
    launch(1);
    ce = 1'b0;
    @(negedge clock); #1;
    chk("stall_req", 32'(o_kern_req), 1);
    @(negedge clock); #1 ce = 1'b1;
    wait_done(1'b0, seen);
    chk("stall_seen", 32'(seen), 1);
    chk("stall_req_cyc", req_hi - r0, 3);
    chk("stall_runs", k_runs - k0, 1);
    chk("stall_iter", 32'(o_iter_done), 1);
    chk("stall_true", 32'(o_true_cnt), 1);
    @(negedge clock); #1;

    // reset during WAIT_DONE of run 2
    busy_len = 6; run_base = k_runs; k0 = k_runs;
    launch(3);
    lim = 0;
    while (!((k_runs - k0) == 2 && k_busy) && lim < 200) begin
      @(negedge clock); #1; lim++;
    end
    chk("rst_reach", 32'(lim < 200), 1);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_iter", 32'(o_iter_done), 0);
    chk("mid_rst_out", {o_done, o_kern_req, o_timeout, o_true_cnt}, 0);
    @(negedge clock); reset_n = 1'b1;
    run_cmd(1, 4, 1'b0, 1'b0, 8'h00);

`ifdef RUN_LAUNCHER_WDOG_EN
    // kernel never answers: abort after WDOG wait cycles
    kern_en = 1'b0; run_base = k_runs;
    launch(2);
    wait_done(1'b0, seen);
    chk("wd_seen", 32'(seen), 1);
    chk("wd_timeout", 32'(o_timeout), 1);
    chk("wd_iter", 32'(o_iter_done), 0);
    chk("wd_latency", cyc - start_cyc, WDOG + 1);
    @(negedge clock); #1;
    chk("wd_sticky", 32'(o_timeout), 1);
    kern_en = 1'b1;
    run_cmd(1, 3, 1'b0, 1'b0, 8'h00);
`endif

    for (int t = 0; t < 12; t++) begin
      run_cmd($urandom_range(0, 5), $urandom_range(1, 6), (t % 3) == 2, 1'b0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_launcher.md
# run_launcher

Upstream control stage for the generated kernels that use the `i_run_req` / `o_run_busy` handshake. On one `i_start` command it launches the attached kernel a programmed number of times, back to back. For each run it waits for the kernel's busy to assert and then deassert. It counts completed runs, and counts the runs for which the kernel's boolean result field was true when the run finished. It sits between the host/register interface and one kernel instance.

## Interface
- `CNT_W`, default 16: width of the iteration count and the result counters.
- `WDOG_CYCLES`, default 1024: ce-cycles allowed per handshake wait. Used only when the watchdog is compiled in.

Ports:
- `clock`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ce`  in  1  clock enable. When low, all state is frozen.
- `i_start`  in  1  start command, sampled when `ce` is high.
- `i_count`  in  CNT_W  number of kernel runs, latched on an accepted `i_start`.
- `o_busy`  out  1  launcher active.
- `o_done`  out  1  one-cycle completion pulse.
- `o_iter_done`  out  CNT_W  kernel runs completed in the current or last command.
- `o_true_cnt`  out  CNT_W  runs that ended with `i_kern_flag` = 1.
- `o_timeout`  out  1  sticky watchdog abort flag.
- `o_kern_req`  out  1  run request to the kernel's `i_run_req`.
- `i_kern_busy`  in  1  from the kernel's `o_run_busy`.
- `i_kern_flag`  in  1  kernel boolean result, e.g. `o_fld_a_0`.

## Operation
- State machine: IDLE, REQ, WAIT_ACK, WAIT_DONE, GAP, FIN. All transitions occur only on cycles with `ce` high.
- IDLE
  - `i_start` = 1 and `i_count` ≠ 0: latch the count; clear `o_iter_done`, `o_true_cnt` and `o_timeout`; go to REQ.
  - `i_start` = 1 and `i_count` = 0: clear the counters and go to FIN. The kernel is never requested.
- REQ: `o_kern_req` = 1 for exactly one ce-cycle, then go to WAIT_ACK.
- WAIT_ACK: on `i_kern_busy` = 1, go to WAIT_DONE.
- WAIT_DONE: on `i_kern_busy` = 0:
  - `o_iter_done` += 1.
  - `o_true_cnt` += `i_kern_flag`, sampled in that same cycle.
  - If this was the last run (`o_iter_done` + 1 == latched count), go to FIN. Otherwise go to GAP.
- GAP: one idle cycle so the kernel is back in its idle method before the next request. Then go to REQ.
- FIN: `o_done` = 1 for one cycle, then go to IDLE.
- `i_start` is ignored in every state other than IDLE.
- Counters are unsigned and cannot wrap, because `o_iter_done` is at most the latched count. They hold their values after FIN until the next accepted start.
- `o_busy` = 1 in every state except IDLE.

## Timing
- Reset values (asynchronous): state IDLE; all outputs 0; latched count 0; watchdog counter 0.
- With `ce` high continuously, an `i_start` accepted at edge N gives:
  - `o_kern_req` high in cycle N+1.
  - Kernel busy high from cycle N+2.
  - WAIT_DONE entered at edge N+2.
- Per-run overhead outside the kernel's busy window is 3 cycles: REQ, GAP, and the WAIT_ACK detect.
- `o_done` rises one cycle after the final busy-low detect.
- `i_count` = 0: `o_done` high in cycle N+1.
- `ce` low: every register holds, including `o_kern_req` and `o_done`. A pulse is therefore stretched over the stall, which matches the kernel's ce-gated sampling.
- `reset_n` deasserted mid-run: immediate return to IDLE with all outputs 0. The kernel shares the reset, so no resynchronisation is needed.

## Configuration
- `RUN_LAUNCHER_WDOG_EN` defined:
  - A ce-cycle counter is cleared on entry to WAIT_ACK and to WAIT_DONE.
  - If it reaches `WDOG_CYCLES` while still waiting: set `o_timeout` = 1, go to FIN (`o_done` pulses), and leave the counters as they are.
  - `o_timeout` stays set until the next accepted start or reset.
- Undefined: `o_timeout` is tied to 0, no counter is built, and the waits are unbounded.

## Structure
- `run_launcher_pkg` holds:
  - the state enum, encoded 3-bit, IDLE = 0;
  - the default constants for `CNT_W` and `WDOG_CYCLES`.
- One sub-module, `run_wdog`: clear/enable/expire counter, instantiated only under `RUN_LAUNCHER_WDOG_EN`.

## Test plan
- `i_count` = 3 with a kernel model (busy for 5 cycles, flag pattern 1,0,1):
  - exactly 3 single-cycle `o_kern_req` pulses;
  - `o_iter_done` = 3, `o_true_cnt` = 2;
  - one `o_done` pulse.
- `i_count` = 0: `o_done` in the cycle after start, `o_kern_req` never asserted, counters 0.
- `i_start` re-asserted during a run: ignored; the final counts match the first command only.
- `ce` toggled 1,0,0,1 during REQ: `o_kern_req` held for 3 cycles; the kernel accepts exactly one run.
- `reset_n` pulled low during WAIT_DONE of run 2: all outputs 0 within the same cycle; a new start with count 1 completes normally.
- `RUN_LAUNCHER_WDOG_EN`, `WDOG_CYCLES` = 8, kernel never raises busy:
  - `o_timeout` = 1 and `o_done` pulse after 8 WAIT_ACK ce-cycles, `o_iter_done` = 0;
  - the next start clears `o_timeout`.
